// File: rtl/core_issue_if.sv
// Core issue controller bus: program control, Core address/result, run status.
interface core_issue_if #(
  parameter int unsigned ADDRESS_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH     = 18,
  parameter int unsigned INTERVAL_WIDTH = 2
);
  logic                      start;
  logic [ADDRESS_WIDTH-1:0]  base;
  logic [ADDRESS_WIDTH:0]    length;
  logic [INTERVAL_WIDTH-1:0] interval;
  logic                      pause;
  logic [DATA_WIDTH-1:0]     result;
  logic [ADDRESS_WIDTH-1:0]  counter;
  logic                      issue;
  logic                      result_valid;
  logic [DATA_WIDTH-1:0]     result_data;
  logic [ADDRESS_WIDTH-1:0]  result_addr;
  logic                      busy;
  logic                      done;

  modport slave (
    input  start, base, length, interval, pause, result,
    output counter, issue, result_valid, result_data, result_addr, busy, done
  );

  modport master (
    output start, base, length, interval, pause, result,
    input  counter, issue, result_valid, result_data, result_addr, busy, done
  );
endinterface

// File: rtl/core_issue_controller.sv
// Issue stage for the calculator Core: address sequencing, latency-matched
// tag pipe, result capture and run completion.
module core_issue_controller #(
  parameter int unsigned ADDRESS_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH     = 18,
  parameter int unsigned CORE_LATENCY   = 3,
  parameter int unsigned INTERVAL_WIDTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  core_issue_if.slave bus
);
  localparam int unsigned AW  = ADDRESS_WIDTH;
  localparam int unsigned LW  = ADDRESS_WIDTH + 1;
  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned IW  = INTERVAL_WIDTH;
  localparam int unsigned LAT = CORE_LATENCY;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] addr;
  } tag_t;

  logic [1:0]    state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [LW-1:0] rem, rem_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [IW-1:0] reload, reload_n;
  logic [AW-1:0] counter, counter_n;
  logic          issue, issue_n;
  logic          busy, busy_n;
  logic          done, done_n;

  logic          do_issue;
  logic [AW-1:0] src_addr;
  logic [LW-1:0] src_rem;
  logic [IW-1:0] src_reload;
  logic          pending;

  tag_t          tags [LAT];
  logic          rv;
  logic [DW-1:0] rdata;
  logic [AW-1:0] raddr;

  function automatic logic [IW-1:0] reload_of(input logic [IW-1:0] iv);
    return (iv == '0) ? '0 : iv - IW'(1);
  endfunction

  // Any tag still behind the oldest one, including the issue now on Counter
  always_comb begin
    pending = issue;
    for (int i = 0; i < int'(LAT) - 1; i++) pending = pending | tags[i].vld;
  end

  // Next-state and registered-output logic; the START edge performs issue 0
  always_comb begin
    state_n    = state;
    addr_n     = addr;
    rem_n      = rem;
    icnt_n     = icnt;
    reload_n   = reload;
    counter_n  = counter;
    issue_n    = 1'b0;
    done_n     = 1'b0;
    do_issue   = 1'b0;
    src_addr   = addr;
    src_rem    = rem;
    src_reload = reload;

    case (state)
      ST_IDLE: begin
        if (bus.start && !busy) begin
          if (bus.length == '0) begin
            done_n = 1'b1;
          end else begin
            do_issue   = 1'b1;
            src_addr   = bus.base;
            src_rem    = bus.length;
            src_reload = reload_of(bus.interval);
          end
        end
      end
      ST_ISSUE: begin
        if (icnt == '0) begin
          do_issue = !bus.pause;
        end else begin
          icnt_n = icnt - IW'(1);
        end
      end
      ST_DRAIN: begin
        if (tags[LAT-1].vld && !pending) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (do_issue) begin
      counter_n = src_addr;
      issue_n   = 1'b1;
      addr_n    = src_addr + AW'(1);
      rem_n     = src_rem - LW'(1);
      icnt_n    = src_reload;
      reload_n  = src_reload;
      state_n   = (src_rem == LW'(1)) ? ST_DRAIN : ST_ISSUE;
    end

    busy_n = (state_n != ST_IDLE) || (state == ST_DRAIN && done_n);
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr    <= '0;
      rem     <= '0;
      icnt    <= '0;
      reload  <= '0;
      counter <= '0;
      issue   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      rem     <= rem_n;
      icnt    <= icnt_n;
      reload  <= reload_n;
      counter <= counter_n;
      issue   <= issue_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Tag pipe never stalls; the oldest tag qualifies the Core result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LAT); i++) tags[i] <= '0;
      rv    <= 1'b0;
      rdata <= '0;
      raddr <= '0;
    end else begin
      tags[0] <= {issue, counter};
      for (int i = 1; i < int'(LAT); i++) tags[i] <= tags[i-1];
      rv <= tags[LAT-1].vld;
      if (tags[LAT-1].vld) begin
        rdata <= bus.result;
        raddr <= tags[LAT-1].addr;
      end
    end
  end

  assign bus.counter      = counter;
  assign bus.issue        = issue;
  assign bus.result_valid = rv;
  assign bus.result_data  = rdata;
  assign bus.result_addr  = raddr;
  assign bus.busy         = busy;
  assign bus.done         = done;
endmodule

// File: tb/tb_core_issue_controller.sv
// Randomised scoreboard bench for core_issue_controller with a 3-cycle Core stub.
module tb_core_issue_controller;
  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 18;
  localparam int unsigned IW  = 2;
  localparam int          LAT = 3;

  typedef struct {
    int c;
    int a;
    int d;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;
  int   busy_lo;
  int   busy_hi;

  ev_t  iss_q[$];
  ev_t  res_q[$];
  int   done_q[$];
  ev_t  mon_e;
  int   mon_d;

  logic [AW-1:0] s0, s1, s2;

  core_issue_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .INTERVAL_WIDTH(IW)) bus ();

  core_issue_controller #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .CORE_LATENCY  (LAT),
    .INTERVAL_WIDTH(IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: Result = Counter + 5, three cycles later
  always @(posedge clk) begin
    s0 <= bus.counter;
    s1 <= s0;
    s2 <= s1;
  end
  assign bus.result = DW'(s2) + DW'(5);

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pbit(input logic [63:0] m, input int r);
    return (r >= 0 && r < 64) ? m[r] : 1'b0;
  endfunction

  // Monitor: pop the scoreboard whenever the DUT presents an event
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.issue) begin
        if (iss_q.size() == 0) chk("issue_unexpected", 1, 0);
        else begin
          mon_e = iss_q.pop_front();
          chk("issue_cycle", cyc, mon_e.c);
          chk("issue_addr", bus.counter, mon_e.a);
        end
      end
      if (bus.result_valid) begin
        if (res_q.size() == 0) chk("result_unexpected", 1, 0);
        else begin
          mon_e = res_q.pop_front();
          chk("result_cycle", cyc, mon_e.c);
          chk("result_addr", bus.result_addr, mon_e.a);
          chk("result_data", bus.result_data, mon_e.d);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mon_d = done_q.pop_front();
          chk("done_cycle", cyc, mon_d);
        end
      end
      chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  // One program run starting in the current cycle. pm bit c gates the issue
  // that would appear c cycles after START. xs: extra START offset, -1 none,
  // -2 random offset inside the busy window.
  task automatic run(input int b, input int len, input int iv,
                     input logic [63:0] pm, input int xs);
    int s, c, d, ive, a, x;
    s   = cyc;
    ive = (iv == 0) ? 1 : iv;
    c   = s + 1;
    if (len == 0) begin
      d = s + 1;
    end else begin
      for (int k = 0; k < len; k++) begin
        if (k > 0) begin
          c = c + ive;
          while (pbit(pm, c - s)) c++;
        end
        a = (b + k) % 1024;
        iss_q.push_back('{c, a, 0});
        res_q.push_back('{c + LAT + 1, a, a + 5});
      end
      d       = c + LAT + 1;
      busy_lo = s + 1;
      busy_hi = d;
    end
    done_q.push_back(d);
    x = xs;
    if (xs == -2) x = (len == 0) ? -1 : $urandom_range(1, d - s);
    for (int r = 0; s + r <= d; r++) begin
      if (r == 0) begin
        bus.start    = 1'b1;
        bus.base     = AW'(b);
        bus.length   = (AW+1)'(len);
        bus.interval = IW'(iv);
      end else begin
        bus.start    = (r == x);
        bus.base     = AW'($urandom);
        bus.length   = (AW+1)'($urandom_range(0, 30));
        bus.interval = IW'($urandom);
      end
      bus.pause = pbit(pm, r + 1);
      step();
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  // Reset in the middle of a 10-instruction run, then restart
  task automatic reset_mid_run();
    int s;
    s = cyc;
    bus.start    = 1'b1;
    bus.base     = '0;
    bus.length   = 11'd10;
    bus.interval = 2'd1;
    for (int k = 0; k < 3; k++) iss_q.push_back('{s + 1 + k, k, 0});
    busy_lo = s + 1;
    busy_hi = s + 3;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_counter", bus.counter, 0);
    chk("rst_issue", bus.issue, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_result_data", bus.result_data, 0);
    chk("rst_result_addr", bus.result_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    step();
    run(20, 2, 1, 64'h0, -1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got no finish, expected finish by 300000");
    $fatal(1, "timeout");
  end

  initial begin
    cyc          = 0;
    checks       = 0;
    errors       = 0;
    mon_en       = 1'b0;
    busy_lo      = 1;
    busy_hi      = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.base     = '0;
    bus.length   = '0;
    bus.interval = '0;
    bus.pause    = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("init_counter", bus.counter, 0);
    chk("init_issue", bus.issue, 0);
    chk("init_result_valid", bus.result_valid, 0);
    chk("init_busy", bus.busy, 0);
    chk("init_done", bus.done, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    run(0, 100, 1, 64'h0, -1);
    run(10, 4, 3, 64'h0, -1);
    run(1022, 4, 1, 64'h0, -1);
    run(0, 5, 1, 64'h38, 4);
    run(0, 0, 1, 64'h0, -1);
    run(0, 1, 1, 64'h0, -1);
    run(7, 3, 0, 64'h0, -1);
    reset_mid_run();
    run(5, 1024, 1, 64'h0, -1);

    for (int n = 0; n < 40; n++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
      run($urandom_range(0, 1023), len, $urandom_range(0, 3),
          {$urandom & $urandom, $urandom & $urandom}, $urandom_range(0, 1) ? -2 : -1);
    end

    repeat (10) step();
    chk("issue_queue_left", iss_q.size(), 0);
    chk("result_queue_left", res_q.size(), 0);
    chk("done_queue_left", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
